// File: rtl/key_detector_pkg.sv
// Shared types and constants for the CW key detector: FSM state encoding,
// default parameter values and the rectifier saturation helper.
package key_detector_pkg;

  localparam int DEF_DATA_WIDTH       = 16;
  localparam int DEF_DECAY_SHIFT      = 6;
  localparam int DEF_DEBOUNCE_SAMPLES = 8;
  localparam int DEF_DURATION_WIDTH   = 24;

  typedef enum logic [1:0] {
    KD_SPACE         = 2'd0,
    KD_MARK_PENDING  = 2'd1,
    KD_MARK          = 2'd2,
    KD_SPACE_PENDING = 2'd3
  } kd_state_e;

  // Largest positive magnitude of a signed sample; |most negative| clamps here.
  function automatic int unsigned rect_sat(input int unsigned width);
    return (32'd1 << (width - 32'd1)) - 32'd1;
  endfunction

  localparam int unsigned RECT_SAT_DEFAULT = rect_sat(DEF_DATA_WIDTH);

endpackage

// File: rtl/key_detector_if.sv
// Sample/threshold input and key/duration output bundle of key_detector.
// The detector side uses the slave modport; the sample source uses master.
interface key_detector_if
  import key_detector_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int DURATION_WIDTH = DEF_DURATION_WIDTH
);
  logic [DATA_WIDTH-1:0]     i_sample;
  logic                      i_valid;
  logic [DATA_WIDTH-1:0]     i_thresholdOn;
  logic [DATA_WIDTH-1:0]     i_thresholdOff;
  logic                      o_key;
  logic                      o_valid;
  logic [DURATION_WIDTH-1:0] o_duration;
  logic                      o_durationValid;
  logic                      o_durationIsMark;

  modport slave (
    input  i_sample, i_valid, i_thresholdOn, i_thresholdOff,
    output o_key, o_valid, o_duration, o_durationValid, o_durationIsMark
  );

  modport master (
    output i_sample, i_valid, i_thresholdOn, i_thresholdOff,
    input  o_key, o_valid, o_duration, o_durationValid, o_durationIsMark
  );
endinterface

// File: rtl/key_detector_envelope_follower.sv
// Rectifier plus peak-hold / leaky-decay envelope follower, one register
// stage each; both stages advance only on qualified samples.
module envelope_follower
  import key_detector_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DECAY_SHIFT = DEF_DECAY_SHIFT
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic [DATA_WIDTH-1:0] i_sample,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_env,
  output logic                  o_valid
);
  localparam logic [DATA_WIDTH-1:0] SAT      = DATA_WIDTH'(rect_sat(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] w_abs;
  logic [DATA_WIDTH-1:0] w_decayed;
  logic [DATA_WIDTH-1:0] w_env_next;
  logic [DATA_WIDTH-1:0] r_abs;
  logic [DATA_WIDTH-1:0] r_env;
  logic                  r_abs_valid;
  logic                  r_env_valid;

  always_comb begin
    w_abs = i_sample;
    if (i_sample == MOST_NEG) begin
      w_abs = SAT;
    end else if (i_sample[DATA_WIDTH-1]) begin
      w_abs = ZERO - i_sample;
    end else begin
      w_abs = i_sample;
    end
  end

  // env >> DECAY_SHIFT never exceeds env, so the subtraction cannot wrap.
  assign w_decayed  = r_env - (r_env >> DECAY_SHIFT);
  assign w_env_next = (r_abs > w_decayed) ? r_abs : w_decayed;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_abs       <= ZERO;
      r_abs_valid <= 1'b0;
    end else begin
      r_abs_valid <= i_valid;
      if (i_valid) begin
        r_abs <= w_abs;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_env       <= ZERO;
      r_env_valid <= 1'b0;
    end else begin
      r_env_valid <= r_abs_valid;
      if (r_abs_valid) begin
        r_env <= w_env_next;
      end
    end
  end

  assign o_env   = r_env;
  assign o_valid = r_env_valid;

endmodule

// File: rtl/key_detector.sv
// CW key detector: envelope follower, hysteresis comparator and debounce FSM.
// Define KEY_DETECTOR_DURATION_EN to build the mark/space duration counter.
module key_detector
  import key_detector_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int DECAY_SHIFT      = DEF_DECAY_SHIFT,
  parameter int DEBOUNCE_SAMPLES = DEF_DEBOUNCE_SAMPLES,
  parameter int DURATION_WIDTH   = DEF_DURATION_WIDTH
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  key_detector_if.slave bus
);
  localparam logic [1:0] S_SPACE         = KD_SPACE;
  localparam logic [1:0] S_MARK_PENDING  = KD_MARK_PENDING;
  localparam logic [1:0] S_MARK          = KD_MARK;
  localparam logic [1:0] S_SPACE_PENDING = KD_SPACE_PENDING;
  localparam logic [7:0] DEB             = 8'(DEBOUNCE_SAMPLES);

  logic [DATA_WIDTH-1:0] w_env;
  logic                  w_env_valid;
  logic [DATA_WIDTH-1:0] w_thr_off;
  logic                  w_above_on;
  logic                  w_below_off;
  logic [7:0]            w_cnt_inc;
  logic [1:0]            w_state_next;
  logic [7:0]            w_cnt_next;
  logic                  w_key_next;
  logic [1:0]            r_state;
  logic [7:0]            r_cnt;
  logic                  r_key;
  logic                  r_valid;

  envelope_follower #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_env (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_sample (bus.i_sample),
    .i_valid  (bus.i_valid),
    .o_env    (w_env),
    .o_valid  (w_env_valid)
  );

  // Clamp thrOff to thrOn so a misprogrammed pair can never invert the hysteresis.
  assign w_thr_off   = (bus.i_thresholdOff < bus.i_thresholdOn) ? bus.i_thresholdOff : bus.i_thresholdOn;
  assign w_above_on  = (w_env >= bus.i_thresholdOn);
  assign w_below_off = (w_env < w_thr_off);
  assign w_cnt_inc   = r_cnt + 8'd1;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_key_next   = r_key;
    if (w_env_valid) begin
      case (r_state)
        S_SPACE: begin
          if (w_above_on) begin
            w_cnt_next = 8'd1;
            if (DEB == 8'd1) begin
              w_state_next = S_MARK;
              w_key_next   = 1'b1;
            end else begin
              w_state_next = S_MARK_PENDING;
            end
          end else begin
            w_state_next = S_SPACE;
          end
        end
        S_MARK_PENDING: begin
          if (w_above_on) begin
            w_cnt_next = w_cnt_inc;
            if (w_cnt_inc == DEB) begin
              w_state_next = S_MARK;
              w_key_next   = 1'b1;
            end else begin
              w_state_next = S_MARK_PENDING;
            end
          end else begin
            w_state_next = S_SPACE;
            w_cnt_next   = 8'd0;
          end
        end
        S_MARK: begin
          if (w_below_off) begin
            w_cnt_next = 8'd1;
            if (DEB == 8'd1) begin
              w_state_next = S_SPACE;
              w_key_next   = 1'b0;
            end else begin
              w_state_next = S_SPACE_PENDING;
            end
          end else begin
            w_state_next = S_MARK;
          end
        end
        S_SPACE_PENDING: begin
          if (w_below_off) begin
            w_cnt_next = w_cnt_inc;
            if (w_cnt_inc == DEB) begin
              w_state_next = S_SPACE;
              w_key_next   = 1'b0;
            end else begin
              w_state_next = S_SPACE_PENDING;
            end
          end else begin
            w_state_next = S_MARK;
            w_cnt_next   = 8'd0;
          end
        end
        default: begin
          w_state_next = S_SPACE;
          w_cnt_next   = 8'd0;
          w_key_next   = 1'b0;
        end
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_SPACE;
      r_cnt   <= 8'd0;
      r_key   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_key   <= w_key_next;
      r_valid <= w_env_valid;
    end
  end

  assign bus.o_key   = r_key;
  assign bus.o_valid = r_valid;

`ifdef KEY_DETECTOR_DURATION_EN
  localparam logic [DURATION_WIDTH-1:0] DUR_ZERO = {DURATION_WIDTH{1'b0}};
  localparam logic [DURATION_WIDTH-1:0] DUR_ONE  = {{(DURATION_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DURATION_WIDTH-1:0] DUR_MAX  = {DURATION_WIDTH{1'b1}};

  logic                      w_toggle;
  logic [DURATION_WIDTH-1:0] r_dur_cnt;
  logic [DURATION_WIDTH-1:0] r_duration;
  logic                      r_dur_valid;
  logic                      r_dur_is_mark;

  assign w_toggle = w_env_valid && (w_key_next != r_key);

  // The toggling sample opens the new interval, so the counter restarts at 1.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_dur_cnt     <= DUR_ZERO;
      r_duration    <= DUR_ZERO;
      r_dur_valid   <= 1'b0;
      r_dur_is_mark <= 1'b0;
    end else begin
      r_dur_valid <= w_toggle;
      if (w_toggle) begin
        r_duration    <= r_dur_cnt;
        r_dur_is_mark <= r_key;
        r_dur_cnt     <= DUR_ONE;
      end else if (w_env_valid && (r_dur_cnt != DUR_MAX)) begin
        r_dur_cnt <= r_dur_cnt + DUR_ONE;
      end
    end
  end

  assign bus.o_duration       = r_duration;
  assign bus.o_durationValid  = r_dur_valid;
  assign bus.o_durationIsMark = r_dur_is_mark;
`else
  assign bus.o_duration       = {DURATION_WIDTH{1'b0}};
  assign bus.o_durationValid  = 1'b0;
  assign bus.o_durationIsMark = 1'b0;
`endif

endmodule

// File: tb/tb_key_detector.sv
// Directed self-checking bench for key_detector (DECAY_SHIFT 6, DEBOUNCE 8).
module tb_key_detector;
  localparam int DW   = 16;
  localparam int DURW = 24;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  key_detector_if #(.DATA_WIDTH(DW), .DURATION_WIDTH(DURW)) bus();

  key_detector #(
    .DATA_WIDTH       (DW),
    .DECAY_SHIFT      (6),
    .DEBOUNCE_SAMPLES (8),
    .DURATION_WIDTH   (DURW)
  ) dut (
    .i_clk    (clk),
    .i_resetn (rstn),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] s, input logic v);
    bus.i_sample = s;
    bus.i_valid  = v;
  endtask

  task automatic set_thr(input logic [DW-1:0] on, input logic [DW-1:0] off);
    bus.i_thresholdOn  = on;
    bus.i_thresholdOff = off;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive(16'd0, 1'b0);
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    set_thr(16'd0, 16'd0);
    do_reset();
    repeat (3) tick();
    checks++; if (bus.o_key !== 1'b0) begin errors++; $display("FAIL reset_key got %0b exp 0", bus.o_key); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.o_valid); end
    checks++; if (bus.o_duration !== 24'd0) begin errors++; $display("FAIL reset_duration got %0d exp 0", bus.o_duration); end
    checks++; if (bus.o_durationValid !== 1'b0) begin errors++; $display("FAIL reset_durvalid got %0b exp 0", bus.o_durationValid); end
    checks++; if (bus.o_durationIsMark !== 1'b0) begin errors++; $display("FAIL reset_durismark got %0b exp 0", bus.o_durationIsMark); end
  endtask

  // Continuous sample s from edge 1: o_valid from edge 3, key from edge 10.
  task automatic test_continuous(input string name, input logic [DW-1:0] s, input logic [DW-1:0] on);
    logic exp_v, exp_k;
    set_thr(on, 16'd4000);
    do_reset();
    drive(s, 1'b1);
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_v = (e >= 3);
      exp_k = (e >= 10);
      checks++; if (bus.o_valid !== exp_v) begin errors++; $display("FAIL %s_valid edge %0d got %0b exp %0b", name, e, bus.o_valid, exp_v); end
      checks++; if (bus.o_key !== exp_k) begin errors++; $display("FAIL %s_key edge %0d got %0b exp %0b", name, e, bus.o_key, exp_k); end
      if (e == 10) begin
`ifdef KEY_DETECTOR_DURATION_EN
        checks++; if (bus.o_durationValid !== 1'b1) begin errors++; $display("FAIL %s_rise_dv got %0b exp 1", name, bus.o_durationValid); end
        checks++; if (bus.o_duration !== 24'd7) begin errors++; $display("FAIL %s_rise_dur got %0d exp 7", name, bus.o_duration); end
        checks++; if (bus.o_durationIsMark !== 1'b0) begin errors++; $display("FAIL %s_rise_ismark got %0b exp 0", name, bus.o_durationIsMark); end
`else
        checks++; if (bus.o_durationValid !== 1'b0) begin errors++; $display("FAIL %s_rise_dv got %0b exp 0", name, bus.o_durationValid); end
`endif
      end
      if (e == 11) begin
        checks++; if (bus.o_durationValid !== 1'b0) begin errors++; $display("FAIL %s_dv_pulse got %0b exp 0", name, bus.o_durationValid); end
      end
    end
  endtask

  // thrOn = thrOff = 32000: env 32765.., 32254, 31751 after the burst.
  task automatic test_burst(input int n, input logic expect_mark);
    logic exp_k;
    set_thr(16'd32000, 16'd32000);
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      drive((e <= n) ? 16'd32765 : 16'd0, 1'b1);
      tick();
      exp_k = expect_mark && (e >= 10);
      checks++; if (bus.o_key !== exp_k) begin errors++; $display("FAIL burst%0d_key edge %0d got %0b exp %0b", n, e, bus.o_key, exp_k); end
    end
  endtask

  // thrOff 20000 > thrOn 8000: fall must follow env < 8000, not < 20000.
  task automatic test_hysteresis();
    int env, d, a, run_on, run_off, fall_on, fall_off;
    env = 0; run_on = 0; run_off = 0; fall_on = -1; fall_off = -1;
    for (int j = 1; j <= 400; j++) begin
      a = (j <= 20) ? 32765 : 0;
      d = env - (env >>> 6);
      env = (a > d) ? a : d;
      if (j > 20) begin
        run_on  = (env < 8000)  ? run_on + 1  : 0;
        run_off = (env < 20000) ? run_off + 1 : 0;
        if (run_on == 8 && fall_on < 0) fall_on = j;
        if (run_off == 8 && fall_off < 0) fall_off = j;
      end
    end
    set_thr(16'd8000, 16'd20000);
    do_reset();
    for (int e = 1; e <= fall_on + 3; e++) begin
      drive((e <= 20) ? 16'd32765 : 16'd0, 1'b1);
      tick();
      if (e == fall_off + 2) begin
        checks++; if (bus.o_key !== 1'b1) begin errors++; $display("FAIL hyst_not_at_throff edge %0d got %0b exp 1", e, bus.o_key); end
      end
      if (e == fall_on + 1) begin
        checks++; if (bus.o_key !== 1'b1) begin errors++; $display("FAIL hyst_before_fall edge %0d got %0b exp 1", e, bus.o_key); end
      end
      if (e == fall_on + 2) begin
        checks++; if (bus.o_key !== 1'b0) begin errors++; $display("FAIL hyst_fall edge %0d got %0b exp 0", e, bus.o_key); end
      end
    end
  endtask

  // Valid on odd edges only: o_valid mirrors it 2 later, 8th sample at edge 15.
  task automatic test_gaps();
    logic exp_v, exp_k;
    set_thr(16'd8000, 16'd4000);
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      drive(16'd32765, (e % 2) == 1);
      tick();
      exp_v = (e >= 3) && (((e - 2) % 2) == 1);
      exp_k = (e >= 17);
      checks++; if (bus.o_valid !== exp_v) begin errors++; $display("FAIL gaps_valid edge %0d got %0b exp %0b", e, bus.o_valid, exp_v); end
      checks++; if (bus.o_key !== exp_k) begin errors++; $display("FAIL gaps_key edge %0d got %0b exp %0b", e, bus.o_key, exp_k); end
    end
  endtask

  task automatic test_duration();
    int  nrep, cnt, e;
    logic counting, seen_key, fell, seen_dv;
    nrep = 0; cnt = 0; counting = 1'b0; seen_key = 1'b0; fell = 1'b0; seen_dv = 1'b0;
    set_thr(16'd8000, 16'd4000);
    do_reset();
    e = 0;
    while (e < 700 && nrep < 2 && !fell) begin
      e++;
      drive((e <= 200) ? 16'd32765 : 16'd0, 1'b1);
      tick();
      if (bus.o_durationValid === 1'b1) seen_dv = 1'b1;
`ifdef KEY_DETECTOR_DURATION_EN
      if (bus.o_durationValid === 1'b1) begin
        nrep++;
        if (nrep == 1) begin
          checks++; if (bus.o_duration !== 24'd7) begin errors++; $display("FAIL dur_space got %0d exp 7", bus.o_duration); end
          checks++; if (bus.o_durationIsMark !== 1'b0) begin errors++; $display("FAIL dur_space_ismark got %0b exp 0", bus.o_durationIsMark); end
          counting = 1'b1;
          cnt = 1;
        end else begin
          checks++; if (bus.o_duration !== 24'(cnt)) begin errors++; $display("FAIL dur_mark got %0d exp %0d", bus.o_duration, cnt); end
          checks++; if (bus.o_durationIsMark !== 1'b1) begin errors++; $display("FAIL dur_mark_ismark got %0b exp 1", bus.o_durationIsMark); end
          checks++; if (bus.o_key !== 1'b0) begin errors++; $display("FAIL dur_fall_key got %0b exp 0", bus.o_key); end
        end
      end else if (counting && bus.o_valid === 1'b1) begin
        cnt++;
      end
`endif
      if (bus.o_key === 1'b1) seen_key = 1'b1;
      if (seen_key && bus.o_key === 1'b0) fell = 1'b1;
    end
`ifdef KEY_DETECTOR_DURATION_EN
    checks++; if (nrep != 2) begin errors++; $display("FAIL dur_timeout reports %0d exp 2", nrep); end
`else
    checks++; if (!fell) begin errors++; $display("FAIL dur_nofall_timeout fell %0b exp 1", fell); end
    checks++; if (seen_dv !== 1'b0) begin errors++; $display("FAIL dur_disabled_dv got %0b exp 0", seen_dv); end
    checks++; if (bus.o_duration !== 24'd0) begin errors++; $display("FAIL dur_disabled_dur got %0d exp 0", bus.o_duration); end
`endif
  endtask

  task automatic test_reset_midmark();
    set_thr(16'd8000, 16'd4000);
    do_reset();
    drive(16'd32765, 1'b1);
    repeat (12) tick();
    checks++; if (bus.o_key !== 1'b1) begin errors++; $display("FAIL midmark_pre_key got %0b exp 1", bus.o_key); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (bus.o_key !== 1'b0) begin errors++; $display("FAIL midmark_async_key got %0b exp 0", bus.o_key); end
    checks++; if (bus.o_durationValid !== 1'b0) begin errors++; $display("FAIL midmark_async_dv got %0b exp 0", bus.o_durationValid); end
    tick();
    checks++; if (bus.o_durationValid !== 1'b0) begin errors++; $display("FAIL midmark_dv got %0b exp 0", bus.o_durationValid); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL midmark_valid got %0b exp 0", bus.o_valid); end
    drive(16'd0, 1'b0);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    drive(16'd0, 1'b0);
    set_thr(16'd0, 16'd0);
    test_reset();
    test_continuous("pos", 16'd32765, 16'd8000);
    test_continuous("neg", 16'h8000, 16'd32767);
    test_burst(5, 1'b0);
    test_burst(7, 1'b1);
    test_hysteresis();
    test_gaps();
    test_duration();
    test_reset_midmark();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_detector.md
# key_detector

Receive-side counterpart of the keying circuit. Takes a stream of signed baseband amplitude samples, which carry shaped CW keying, and recovers the debounced key state. It rectifies each sample, tracks the envelope with a peak-hold/leaky-decay follower, and applies a hysteresis comparator and a debounce state machine. It sits after the receive-chain demodulator and drives the CW decoder/sidetone logic, with optional mark/space duration measurement.

## Interface
- DATA_WIDTH, 16: sample width, signed two's complement.
- DECAY_SHIFT, 6: envelope decay per valid sample is env >> DECAY_SHIFT.
- DEBOUNCE_SAMPLES, 8: consecutive qualifying samples needed to change key state (range 1..255).
- DURATION_WIDTH, 24: width of the mark/space duration counter.
- i_clk  in  1  system clock, rising edge.
- i_resetn  in  1  asynchronous, active-low reset.
- i_sample  in  DATA_WIDTH  signed input sample.
- i_valid  in  1  qualifies i_sample; at most one sample per clock.
- i_thresholdOn  in  DATA_WIDTH  unsigned envelope level that starts a mark.
- i_thresholdOff  in  DATA_WIDTH  unsigned envelope level below which a mark ends.
- o_key  out  1  debounced key state; 1 = mark.
- o_valid  out  1  one-cycle pulse each time a sample has been processed by the FSM.
- o_duration  out  DURATION_WIDTH  length of the completed interval, in samples.
- o_durationValid  out  1  one-cycle pulse when o_duration is updated.
- o_durationIsMark  out  1  1 if the reported interval was a mark, 0 if a space.

## Operation
- Stage 1 (rectify): abs = |i_sample|. The most negative value saturates to 2^(DATA_WIDTH-1)-1.
- Stage 2 (envelope): env = max(abs, env - (env >> DECAY_SHIFT)). The value is unsigned, updates only on valid samples, and never underflows.
- Effective off threshold thrOff = min(i_thresholdOff, i_thresholdOn). This keeps the hysteresis non-inverted when the thresholds are misprogrammed.
- Stage 3 is an FSM with debounce counter cnt. It acts only on valid samples.
  - SPACE: if env >= thrOn, set cnt = 1 and go to MARK_PENDING. This step completes immediately if DEBOUNCE_SAMPLES = 1.
  - MARK_PENDING: if env >= thrOn, increment cnt; when cnt reaches DEBOUNCE_SAMPLES, go to MARK and set o_key = 1. If env < thrOn, return to SPACE.
  - MARK: if env < thrOff, set cnt = 1 and go to SPACE_PENDING.
  - SPACE_PENDING: if env < thrOff, increment cnt; when cnt reaches DEBOUNCE_SAMPLES, go to SPACE and set o_key = 0. If env >= thrOff, return to MARK.
- Threshold inputs are sampled every valid sample. A threshold change mid-pending takes effect on the next sample.
- Reset values: env = 0, state = SPACE, cnt = 0, o_key = 0, o_valid = 0, o_duration = 0, o_durationValid = 0, o_durationIsMark = 0, duration counter = 0.
- Reset asserted mid-mark drops o_key to 0 immediately, with no clock needed, and emits no duration report.

## Timing
- Pipeline latency: a sample captured at edge N updates the FSM, o_key and o_valid at edge N+2.
- o_valid follows i_valid delayed by 2 cycles, pulse for pulse.
- Back-to-back valid samples are supported at full clock rate. Gaps in i_valid stall every stage; no state decays during gaps.
- o_key changes only on the edge that completes debounce. The earliest mark is at DEBOUNCE_SAMPLES qualifying samples + 2 cycles.
- o_durationValid pulses on the same edge that o_key toggles.

## Configuration
- KEY_DETECTOR_DURATION_EN defined:
  - A duration counter counts valid samples in the current debounced state. It is cleared to 1 on the sample that toggles o_key and saturates at 2^DURATION_WIDTH-1.
  - On each toggle, the counter value before clearing is presented on o_duration, and o_durationIsMark shows the state just left.
  - The first report after reset is a space, measured from reset release.
- Not defined: no counter is built; o_duration, o_durationValid and o_durationIsMark are tied to 0.

## Structure
- key_detector_pkg:
  - FSM state enum (SPACE, MARK_PENDING, MARK, SPACE_PENDING).
  - Rectify saturation constant.
  - Default parameter constants.
- Sub-module envelope_follower holds stages 1–2: sample in, env out, valid out, one cycle each. The FSM and duration counter stay in key_detector.

## Test plan
Common settings: DECAY_SHIFT 6, DEBOUNCE_SAMPLES 8.
- Reset with all inputs idle → every output 0. Assert reset mid-mark → o_key = 0 asynchronously, no o_durationValid pulse.
- Continuous 32765 with thrOn 8000, thrOff 4000 → o_key rises 2 cycles after the 8th sample is captured; o_valid pulses on every cycle from the 3rd edge.
- thrOn = thrOff = 32000, 5-sample burst of 32765 then zeros → env 32765, 32254, 31751; o_key stays 0. A 7-sample burst instead → MARK reached on the 1st zero sample (cnt 8).
- Continuous -32768 → env = 32767, key asserts exactly as for +32767.
- thrOff programmed at 20000 > thrOn 8000 → the key falls when env < 8000, not < 20000.
- Duration enabled, 32765 for 200 samples then zeros → o_duration on the falling toggle equals the bench count of valid samples between the rise and fall toggles, o_durationIsMark = 1. The rising toggle reports a space with o_durationIsMark = 0.
